// File: rtl/rand_sampler.sv
// Rejection sampler: packs LFSR bits MSB-first into WIDTH-bit words and keeps those below LIMIT in a 2-entry FIFO.
// Optional reject statistics counter enabled by defining RAND_SAMPLER_STATS_EN.
module rand_sampler #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       reject_cnt
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {FILL, STALL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-2:0] shreg;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] fifo0, fifo1;
  logic [1:0]       count;
  logic             word_done, word_ok, pop, space;
  logic             push, to_stall;
  logic [WIDTH-1:0] push_data;

  // shreg keeps only WIDTH-1 bits; the newest bit completes the word combinationally
  assign word      = {shreg, rnd};
  assign word_done = (state == FILL) && (bitcnt == CW'(WIDTH - 1));
  assign word_ok   = {1'b0, word} < (WIDTH + 1)'(LIMIT);
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign space     = (count != 2'd2) || pop;
  assign out_data  = fifo0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (word_done && word_ok && !space) state_nxt = STALL;
      STALL:   if (space) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    to_stall  = 1'b0;
    push_data = word;
    case (state)
      FILL: begin
        if (word_done && word_ok) begin
          push     = space;
          to_stall = !space;
        end
      end
      STALL: begin
        push_data = cand;
        push      = space;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      bitcnt <= '0;
      cand   <= '0;
    end else begin
      if (state == FILL) begin
        shreg  <= word[WIDTH-2:0];
        bitcnt <= word_done ? '0 : bitcnt + 1'b1;
      end else if (space) begin
        bitcnt <= '0;
      end
      if (to_stall) cand <= word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo0 <= '0;
      fifo1 <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) fifo0 <= push_data;
          else               fifo1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          fifo0 <= fifo1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // simultaneous push/pop: new word queues behind the surviving entry
          if (count == 2'd1) fifo0 <= push_data;
          else begin
            fifo0 <= fifo1;
            fifo1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAND_SAMPLER_STATS_EN
  logic [7:0] rej_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        rej_q <= '0;
    else if (word_done && !word_ok && rej_q != 8'hFF) rej_q <= rej_q + 8'd1;
  end

  assign reject_cnt = rej_q;
`else
  assign reject_cnt = '0;
`endif

endmodule

// File: tb/tb_rand_sampler.sv
// Scoreboard bench for rand_sampler: a pending-value queue model predicts accepted words; a monitor checks pops.
module tb_rand_sampler;

  localparam int unsigned W = 4;
  localparam int unsigned L = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rnd = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [7:0]   reject_cnt;

  rand_sampler #(.WIDTH(W), .LIMIT(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rnd       (rnd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Model: every accepted-but-unconsumed value (FIFO + held candidate); with 3 pending, input bits are dropped.
  int unsigned pend[$];
  int unsigned sb[$];
  int unsigned acc = 0;
  int unsigned nb = 0;
  int unsigned rejects = 0;

  task automatic check(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int exp_rej();
`ifdef RAND_SAMPLER_STATS_EN
    return (rejects > 255) ? 255 : int'(rejects);
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", 1, 0);
      end else begin
        check("pop_data", int'(out_data), int'(sb.pop_front()));
      end
    end
  end

  task automatic cycle(input bit b, input bit r);
    bit popped;
    rnd = b;
    out_ready = r;
    @(posedge clk);
    popped = (pend.size() > 0) && r;
    if (pend.size() == 3) begin
      if (popped) void'(pend.pop_front());
    end else begin
      if (popped) void'(pend.pop_front());
      acc = acc * 2 + b;
      nb++;
      if (nb == W) begin
        if (acc < L) begin
          pend.push_back(acc);
          sb.push_back(acc);
        end else begin
          rejects++;
        end
        acc = 0;
        nb = 0;
      end
    end
    #1;
    check("out_valid", int'(out_valid), (pend.size() > 0) ? 1 : 0);
    check("reject_cnt", int'(reject_cnt), exp_rej());
  endtask

  task automatic word(input int unsigned v, input bit r);
    for (int i = int'(W) - 1; i >= 0; i--) cycle(((v >> i) & 1) != 0, r);
  endtask

  task automatic clear_model();
    pend.delete();
    sb.delete();
    acc = 0;
    nb = 0;
    rejects = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", int'(out_valid), 0);
    check("reset_data", int'(out_data), 0);
    check("reset_rej", int'(reject_cnt), 0);
    rst_n = 1'b1;

    // basic accept: 0111 -> 7
    word(7, 1'b1);
    check("basic_data", int'(out_data), 7);
    check("basic_valid", int'(out_valid), 1);

    // reject 11 then accept 2
    word(11, 1'b1);
    word(2, 1'b1);
    check("rej_acc_data", int'(out_data), 2);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);

    // full/stall: 3,5 fill FIFO, 9 held, next four bits ignored
    do_reset();
    word(3, 1'b0);
    word(5, 1'b0);
    word(9, 1'b0);
    word(15, 1'b0);
    check("stall_head", int'(out_data), 3);
    cycle(1'b0, 1'b1);
    check("stall_after_pop", int'(out_data), 5);
    repeat (12) cycle(1'b1, 1'b1);

    // push+pop with one entry: 3 popped on the edge 5 is pushed
    do_reset();
    word(3, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    check("pp1_data", int'(out_data), 5);
    cycle(1'b1, 1'b0);
    check("pp1_valid", int'(out_valid), 1);
    check("pp1_hold", int'(out_data), 5);
    repeat (8) cycle(1'b1, 1'b1);

    // asynchronous reset mid-word
    word(7, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_data", int'(out_data), 0);
    clear_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    word(6, 1'b0);
    check("post_rst_data", int'(out_data), 6);
    repeat (4) cycle(1'b1, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0);
    repeat (16) cycle(1'b1, 1'b1);
    check("drain_empty", sb.size(), 0);

    // saturation: 300 rejected words of 15
    do_reset();
    for (int i = 0; i < 300; i++) word(15, 1'b1);
`ifdef RAND_SAMPLER_STATS_EN
    check("sat_rej", int'(reject_cnt), 255);
`else
    check("sat_rej", int'(reject_cnt), 0);
`endif
    check("sat_valid", int'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rand_sampler.md
# rand_sampler

Consumes the one-bit-per-clock pseudo-random stream from the game's LFSR. It packs the bits into WIDTH-bit candidate words and rejection-samples them so that only values below LIMIT are kept. Accepted values go to a 2-entry output FIFO behind a valid/ready handshake. It sits directly downstream of the LFSR and supplies uniformly distributed small integers (e.g. spawn positions, directions) to game logic.

## Interface
- `WIDTH`, default 4: bits per candidate word; legal range 2..8.
- `LIMIT`, default 10: accept candidate iff value < LIMIT; legal range 1..2^WIDTH.
- `clk` input 1: clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `rnd` input 1: random bit from LFSR, sampled every cycle while collecting.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer accepts head this cycle.
- `out_data` output WIDTH: FIFO head value, always < LIMIT when out_valid=1.
- `reject_cnt` output 8: count of rejected candidates (see Configuration).

## Operation
- Reset values:
  - state=FILL, bit counter=0, shift register=0, candidate register=0.
  - FIFO count=0, so out_valid=0.
  - out_data=0, reject_cnt=0.
- FILL state, each cycle:
  - shreg <= {shreg[WIDTH-2:0], rnd}; bitcnt increments.
  - On the cycle bitcnt==WIDTH-1 the word is complete. word = {shreg[WIDTH-2:0], rnd}, so the first-received bit is the MSB.
- Word-complete decision, taken at the same edge:
  - word >= LIMIT: discard, reject_cnt increments, bitcnt<=0, stay in FILL.
  - word < LIMIT and space available: push word, bitcnt<=0, stay in FILL. Space is available when FIFO count<2, or count==2 with a pop this cycle.
  - word < LIMIT and no space: latch word into the candidate register, go to STALL.
- STALL state:
  - rnd is ignored and shreg/bitcnt hold.
  - On the first cycle with space (count<2, or a pop this cycle), push the candidate, set bitcnt<=0, go to FILL.
- FIFO: 2 entries. Pop when out_valid && out_ready.
  - Push+pop in the same cycle: count is unchanged, and ordering is preserved (the pushed word goes behind the remaining entry).
  - When count==1, out_data becomes the pushed word only after the existing head has been popped.
- out_ready while out_valid=0 has no effect.
- LIMIT==2^WIDTH: no word is ever rejected.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); the partially collected word is lost.

## Timing
- Pop latency: out_data/out_valid update on the edge that pops.
- Accept latency: an accepted word is visible on out_data/out_valid on the edge that completes it, i.e. at the WIDTH-th edge of its collection.
- First possible out_valid after reset release: the WIDTH-th rising edge.
- Throughput: at most one accepted word per WIDTH cycles.
- No combinational path from out_ready to out_valid or out_data.
- out_ready may be combinational from out_valid.
- out_valid, once high, stays high until a pop empties the FIFO.

## Configuration
- `RAND_SAMPLER_STATS_EN` defined:
  - reject_cnt is an 8-bit counter that increments once per rejected word.
  - It saturates at 255 and clears only on reset.
- Not defined: reject_cnt is tied to 0 and no counter flops are built. Sampling behaviour is identical either way.

## Test plan
All scenarios use WIDTH=4, LIMIT=10, out_ready=1 unless stated.
- Basic accept: after reset, drive rnd=0,1,1,1 -> out_valid=1 with out_data=7 after the 4th edge; reject_cnt=0.
- Reject then accept: drive rnd=1,0,1,1 then 0,0,1,0 -> no output after the first word (11 rejected); out_data=2 after the 8th edge; reject_cnt=1 with the macro, 0 without.
- Full/stall: out_ready=0, feed accepted words 3, 5, 9 -> FIFO holds 3,5; STALL holds 9 and bits are ignored. Raise out_ready for one cycle -> 3 popped and 9 pushed on the same edge. Sequence read out: 3, 5, 9.
- Simultaneous push+pop with FIFO count==1: count stays 1 and order is preserved.
- Reset mid-word: after 2 bits, assert rst_n=0 asynchronously -> out_valid=0 immediately. Next word collection restarts from bitcnt 0.
- Saturation (macro on): feed 300 words of value 15 -> reject_cnt=255, out_valid stays 0.
